// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32 pipeline types.
//   instr_pkt          : instruction/result packet travelling issue -> execute -> CDB.
//   m_op_*             : funct3 encodings of the M-extension multiply ops.
//   mul_issue_stats_t  : statistics bundle of the multiply issue controller
//                        (only populated when MUL_ISSUE_STATS_EN is defined).
package rv32i_types;

    localparam logic [2:0] m_op_mul    = 3'b000;
    localparam logic [2:0] m_op_mulh   = 3'b001;
    localparam logic [2:0] m_op_mulhsu = 3'b010;
    localparam logic [2:0] m_op_mulhu  = 3'b011;

    typedef struct packed {
        logic        i_valid;
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] rd_data;
    } instr_pkt;

    typedef struct packed {
        logic [31:0] issued;
        logic [31:0] credit_stall;
        logic [31:0] cdb_stall;
    } mul_issue_stats_t;

endpackage

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: round-robin arbiter with internal priority pointer.
//   clk, rst : clock, synchronous active-high reset (ptr -> 0)
//   en       : grants allowed this cycle; when low, gnt=0 and ptr holds
//   req      : NUM_REQ request bits
//   gnt      : one-hot grant (combinational); ptr moves past the winner
module mul_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PW'((32'(ptr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_next = PW'((32'(idx) + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_next;
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: shares one non-stallable pipelined multiplier among NUM_REQ
// multiply reservation stations and buffers results for CDB writeback.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : kills queued and in-flight multiply ops (ptr kept)
//   req_valid  : requester i holds a ready op;  req_pkt[i] : its packet
//   req_ready  : one-hot grant, op i accepted this cycle
//   ex_pkt     : multiplier input packet (all zeros when no grant)
//   mul_pkt    : multiplier output packet, LAT = NUM_STAGES-1 cycles later
//   cdb_valid/cdb_pkt/cdb_ready : result FIFO head handshake toward CDB
//   busy       : any op in flight or buffered
// Optional build macro MUL_ISSUE_STATS_EN adds stat_issued, stat_credit_stall
// and stat_cdb_stall (32-bit wrapping counters, cleared by rst only).
module mul_issue_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  instr_pkt [NUM_REQ-1:0]   req_pkt,
    output logic [NUM_REQ-1:0]       req_ready,
    output instr_pkt                 ex_pkt,
    input  instr_pkt                 mul_pkt,
    output logic                     cdb_valid,
    output instr_pkt                 cdb_pkt,
    input  logic                     cdb_ready,
    output logic                     busy
`ifdef MUL_ISSUE_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_credit_stall,
    output logic [31:0]              stat_cdb_stall
`endif
);

    localparam int unsigned LAT = NUM_STAGES - 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    logic [LAT-1:0] shv;
    instr_pkt       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;
    int unsigned    inflight;
    logic           issue_ok;
    logic           grant;
    logic           push;
    logic           pop;

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < LAT; i++) inflight += 32'(shv[i]);
    end

    // Every op in flight or buffered holds one FIFO slot, so a result can
    // always be captured even though the multiplier never stalls.
    assign issue_ok = !rst && !flush && (inflight + 32'(fifo_count) < FIFO_DEPTH);

    mul_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (issue_ok),
        .req (req_valid),
        .gnt (req_ready)
    );

    assign grant = |req_ready;

    always_comb begin
        ex_pkt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) ex_pkt = req_pkt[i];
        end
        if (grant) ex_pkt.i_valid = 1'b1;
    end

    // Results whose shadow bit was cleared by flush/reset are dropped here.
    assign push      = shv[0] && mul_pkt.i_valid;
    assign cdb_valid = (fifo_count != '0);
    assign cdb_pkt   = fifo_mem[rd_ptr];
    assign pop       = cdb_valid && cdb_ready;
    assign busy      = (|shv) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            shv        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            shv <= {grant, shv[LAT-1:1]};
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mul_pkt;
    end

`ifdef MUL_ISSUE_STATS_EN
    mul_issue_stats_t stats;

    always_ff @(posedge clk) begin
        if (rst) begin
            stats <= '0;
        end else begin
            if (grant)
                stats.issued <= stats.issued + 32'd1;
            if ((|req_valid) && !issue_ok && !flush)
                stats.credit_stall <= stats.credit_stall + 32'd1;
            if (cdb_valid && !cdb_ready)
                stats.cdb_stall <= stats.cdb_stall + 32'd1;
        end
    end

    assign stat_issued       = stats.issued;
    assign stat_credit_stall = stats.credit_stall;
    assign stat_cdb_stall    = stats.cdb_stall;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
`timescale 1ns/1ps
module tb_mul_issue_ctrl;
    import rv32i_types::*;

    localparam int NR      = 4;
    localparam int NS      = 6;
    localparam int LAT     = NS - 1;
    localparam int DEPTH   = 4;
    localparam int DEPTH_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, cdb_valid, cdb_ready, busy;
    logic [NR-1:0]     req_valid, req_ready;
    instr_pkt [NR-1:0] req_pkt;
    instr_pkt          ex_pkt, mul_pkt, cdb_pkt;

    logic              flush_b, cv_b, cr_b, busy_b;
    logic [NR-1:0]     rv_b, rr_b;
    instr_pkt [NR-1:0] rp_b;
    instr_pkt          ex_b, mul_b, cp_b;
`ifdef MUL_ISSUE_STATS_EN
    logic [31:0] st_i, st_c, st_s, st_i_b, st_c_b, st_s_b;
`endif

    mul_issue_ctrl #(.NUM_REQ(NR), .NUM_STAGES(NS), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_pkt(req_pkt),
        .req_ready(req_ready), .ex_pkt(ex_pkt), .mul_pkt(mul_pkt), .cdb_valid(cdb_valid),
        .cdb_pkt(cdb_pkt), .cdb_ready(cdb_ready), .busy(busy)
`ifdef MUL_ISSUE_STATS_EN
        , .stat_issued(st_i), .stat_credit_stall(st_c), .stat_cdb_stall(st_s)
`endif
    );

    mul_issue_ctrl #(.NUM_REQ(NR), .NUM_STAGES(NS), .FIFO_DEPTH(DEPTH_B)) u_dut16 (
        .clk(clk), .rst(rst), .flush(flush_b), .req_valid(rv_b), .req_pkt(rp_b),
        .req_ready(rr_b), .ex_pkt(ex_b), .mul_pkt(mul_b), .cdb_valid(cv_b),
        .cdb_pkt(cp_b), .cdb_ready(cr_b), .busy(busy_b)
`ifdef MUL_ISSUE_STATS_EN
        , .stat_issued(st_i_b), .stat_credit_stall(st_c_b), .stat_cdb_stall(st_s_b)
`endif
    );

    // Reference arithmetic of the M-extension multiply ops.
    function automatic logic [31:0] ref_mul(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            m_op_mul:    begin p = ua * ub; return p[31:0];  end
            m_op_mulh:   begin p = sa * sb; return p[63:32]; end
            m_op_mulhsu: begin p = sa * ub; return p[63:32]; end
            m_op_mulhu:  begin p = ua * ub; return p[63:32]; end
            default:     return 32'd0;
        endcase
    endfunction

    function automatic instr_pkt mul_unit(instr_pkt p);
        instr_pkt r;
        r = p;
        if (p.i_valid) r.rd_data = ref_mul(p.funct3, p.rs1_data, p.rs2_data);
        return r;
    endfunction

    // Environment: pipelined multiplier with fixed latency LAT, never stalls.
    instr_pkt pipe_a [LAT];
    instr_pkt pipe_b [LAT];
    always @(posedge clk) begin
        pipe_a[0] <= mul_unit(ex_pkt);
        pipe_b[0] <= mul_unit(ex_b);
        for (int k = 1; k < LAT; k++) begin
            pipe_a[k] <= pipe_a[k-1];
            pipe_b[k] <= pipe_b[k-1];
        end
    end
    assign mul_pkt = pipe_a[LAT-1];
    assign mul_b   = pipe_b[LAT-1];

    always @(posedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && u_dut.shv[0] === 1'b1 && mul_pkt.i_valid === 1'b1)
            assert (int'(u_dut.fifo_count) < DEPTH)
                else $error("FAIL push_while_full count=%0d", u_dut.fifo_count);
    end

    // Reference model: ordered list of outstanding ops, each visible on the
    // CDB from grant_cycle+LAT+1 onward; credits = DEPTH - outstanding.
    typedef struct { int vis; instr_pkt p; } ent_t;
    ent_t mq[$];
    int   mptr, cyc, tagc;
    int   n_cmp, n_err, n_grants;
    int   obs_grant;
    logic obs_cv, obs_busy;
    instr_pkt obs_cp;
    int   gnt_tags[$], pop_tags[$];

    function automatic instr_pkt mk(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        instr_pkt p;
        p          = '0;
        p.tag      = 4'(tagc);
        p.rd       = 5'(tagc);
        p.funct3   = f3;
        p.rs1_data = a;
        p.rs2_data = b;
        tagc++;
        return p;
    endfunction

    task automatic rand_pkts();
        for (int i = 0; i < NR; i++) req_pkt[i] = mk(3'($urandom_range(0, 3)), $urandom, $urandom);
    endtask

    task automatic clear_logs();
        gnt_tags.delete();
        pop_tags.delete();
        n_grants = 0;
    endtask

    task automatic tick();
        int eg;
        logic [NR-1:0] erdy;
        instr_pkt eex;
        logic ecv, ebusy;
        @(negedge clk);
        eg = -1;
        if (!rst && !flush && mq.size() < DEPTH)
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (mptr + k) % NR;
                if (eg < 0 && req_valid[i]) eg = i;
            end
        erdy = '0;
        eex  = '0;
        if (eg >= 0) begin
            erdy[eg]    = 1'b1;
            eex         = req_pkt[eg];
            eex.i_valid = 1'b1;
        end
        ecv   = (mq.size() > 0) && (mq[0].vis <= cyc);
        ebusy = (mq.size() > 0);
        n_cmp++;
        if (req_ready !== erdy) begin
            n_err++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, erdy);
        end
        n_cmp++;
        if (ex_pkt !== eex) begin
            n_err++;
            $display("FAIL ex_pkt cyc=%0d got=%h exp=%h", cyc, ex_pkt, eex);
        end
        n_cmp++;
        if (cdb_valid !== ecv) begin
            n_err++;
            $display("FAIL cdb_valid cyc=%0d got=%b exp=%b", cyc, cdb_valid, ecv);
        end
        if (ecv) begin
            n_cmp++;
            if (cdb_pkt !== mq[0].p) begin
                n_err++;
                $display("FAIL cdb_pkt cyc=%0d got=%h exp=%h", cyc, cdb_pkt, mq[0].p);
            end
        end
        n_cmp++;
        if (busy !== ebusy) begin
            n_err++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, ebusy);
        end
        obs_grant = -1;
        for (int i = 0; i < NR; i++) if (req_ready[i] === 1'b1) obs_grant = i;
        obs_cv   = cdb_valid;
        obs_cp   = cdb_pkt;
        obs_busy = busy;
        if (obs_grant >= 0) begin
            n_grants++;
            gnt_tags.push_back(int'(ex_pkt.tag));
        end
        if (cdb_valid === 1'b1 && cdb_ready && !flush && !rst) pop_tags.push_back(int'(cdb_pkt.tag));
        if (rst) begin
            mq.delete();
            mptr = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (ecv && cdb_ready) void'(mq.pop_front());
            if (eg >= 0) begin
                ent_t e;
                e.vis = cyc + LAT + 1;
                e.p   = mul_unit(eex);
                mq.push_back(e);
                mptr = (eg + 1) % NR;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        req_valid = '0;
        cdb_ready = 1'b1;
        flush     = 1'b0;
        while ((busy !== 1'b0 || mq.size() > 0) && k < 60) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout busy=%b exp=0", busy);
        end
    endtask

    task automatic compare_order(string name);
        n_cmp++;
        if (pop_tags.size() != gnt_tags.size()) begin
            n_err++;
            $display("FAIL %s_count popped=%0d granted=%0d", name, pop_tags.size(), gnt_tags.size());
        end else begin
            foreach (gnt_tags[i]) begin
                n_cmp++;
                if (pop_tags[i] != gnt_tags[i]) begin
                    n_err++;
                    $display("FAIL %s_order idx=%0d got_tag=%0d exp_tag=%0d", name, i, pop_tags[i], gnt_tags[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        rand_pkts();
        tick();
        tick();
        rst = 1'b0;
        req_valid = '0;
        n_cmp++;
        if (req_ready !== '0) begin n_err++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        n_cmp++;
        if (ex_pkt.i_valid !== 1'b0) begin n_err++; $display("FAIL rst_ex_valid got=%b exp=0", ex_pkt.i_valid); end
        n_cmp++;
        if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL rst_cdb_valid got=%b exp=0", cdb_valid); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        req_valid = '1;
        tick();
        n_cmp++;
        if (obs_grant != 0) begin n_err++; $display("FAIL rst_first_grant got=%0d exp=0", obs_grant); end
        drain();
    endtask

    task automatic run_one(input int r, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int first, output logic [31:0] rd, output logic busy_after);
        cdb_ready = 1'b1;
        rand_pkts();
        req_pkt[r] = mk(f3, a, b);
        req_valid  = '0;
        req_valid[r] = 1'b1;
        tick();
        n_cmp++;
        if (obs_grant != r) begin n_err++; $display("FAIL one_grant got=%0d exp=%0d", obs_grant, r); end
        req_valid = '0;
        first = -1;
        rd = '0;
        busy_after = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (first < 0 && obs_cv === 1'b1) begin
                first = k;
                rd = obs_cp.rd_data;
            end
            if (first > 0 && k == first + 1) busy_after = obs_busy;
        end
    endtask

    task automatic test_single_op();
        int first;
        logic [31:0] rd;
        logic ba;
        drain();
        run_one(2, m_op_mul, 32'd7, 32'd6, first, rd, ba);
        n_cmp++;
        if (first != LAT + 1) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d", first, LAT + 1); end
        n_cmp++;
        if (rd !== 32'd42) begin n_err++; $display("FAIL single_rd got=%0d exp=42", rd); end
        n_cmp++;
        if (ba !== 1'b0) begin n_err++; $display("FAIL single_busy_after_pop got=%b exp=0", ba); end
    endtask

    task automatic test_mulhu();
        int first;
        logic [31:0] rd;
        logic ba;
        drain();
        run_one(1, m_op_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, first, rd, ba);
        n_cmp++;
        if (rd !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu_rd got=%h exp=fffffffe", rd); end
        run_one(3, m_op_mulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, first, rd, ba);
        n_cmp++;
        if (rd !== 32'h0000_0000) begin n_err++; $display("FAIL mulh_rd got=%h exp=00000000", rd); end
    endtask

    task automatic test_fairness();
        int cnt [NR];
        logic [NR-1:0] exp_g;
        foreach (cnt[i]) cnt[i] = 0;
        cr_b = 1'b1;
        for (int i = 0; i < NR; i++) rp_b[i] = mk(m_op_mul, 32'(i), 32'd3);
        rv_b = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_g = '0;
            exp_g[c % NR] = 1'b1;
            n_cmp++;
            if (rr_b !== exp_g) begin
                n_err++;
                $display("FAIL fair_order cycle=%0d got=%b exp=%b", c, rr_b, exp_g);
            end
            for (int i = 0; i < NR; i++) if (rr_b[i] === 1'b1) cnt[i]++;
            @(posedge clk);
            #1;
        end
        rv_b = '0;
        for (int i = 0; i < NR; i++) begin
            n_cmp++;
            if (cnt[i] != 2) begin n_err++; $display("FAIL fair_count req=%0d got=%0d exp=2", i, cnt[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic prev_pop;
        int npop;
        drain();
        clear_logs();
        cdb_ready = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            rand_pkts();
            tick();
        end
        n_cmp++;
        if (n_grants != DEPTH) begin n_err++; $display("FAIL bp_grants got=%0d exp=%0d", n_grants, DEPTH); end
        n_cmp++;
        if (obs_grant != -1) begin n_err++; $display("FAIL bp_stalled got=%0d exp=-1", obs_grant); end
        cdb_ready = 1'b1;
        prev_pop = 1'b0;
        for (int k = 0; k < 18; k++) begin
            rand_pkts();
            npop = pop_tags.size();
            tick();
            n_cmp++;
            if ((obs_grant >= 0) !== prev_pop) begin
                n_err++;
                $display("FAIL bp_grant_per_pop k=%0d got_grant=%0d exp_grant=%b", k, obs_grant, prev_pop);
            end
            prev_pop = (pop_tags.size() > npop);
        end
        drain();
        compare_order("bp");
    endtask

    task automatic test_flush();
        int early_cv, first, new_tag;
        logic [31:0] rd;
        drain();
        clear_logs();
        cdb_ready = 1'b1;
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            rand_pkts();
            tick();
        end
        n_cmp++;
        if (n_grants != 3) begin n_err++; $display("FAIL flush_issue got=%0d exp=3", n_grants); end
        req_valid = '0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_logs();
        req_pkt[0] = mk(m_op_mul, 32'd3, 32'd5);
        new_tag = int'(req_pkt[0].tag);
        req_valid = 4'b0001;
        tick();
        n_cmp++;
        if (obs_grant != 0) begin n_err++; $display("FAIL flush_regrant got=%0d exp=0", obs_grant); end
        req_valid = '0;
        early_cv = 0;
        first = -1;
        rd = '0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (obs_cv === 1'b1 && first < 0) begin
                first = k;
                rd = obs_cp.rd_data;
            end
            if (k < LAT + 1 && obs_cv !== 1'b0) early_cv++;
        end
        n_cmp++;
        if (early_cv != 0) begin n_err++; $display("FAIL flush_stale_cdb got=%0d exp=0", early_cv); end
        n_cmp++;
        if (first != LAT + 1) begin n_err++; $display("FAIL flush_new_latency got=%0d exp=%0d", first, LAT + 1); end
        n_cmp++;
        if (rd !== 32'd15) begin n_err++; $display("FAIL flush_new_rd got=%0d exp=15", rd); end
        n_cmp++;
        if (pop_tags.size() != 1 || pop_tags[0] != new_tag) begin
            n_err++;
            $display("FAIL flush_pops got=%0d exp=1 (tag %0d)", pop_tags.size(), new_tag);
        end
    endtask

    task automatic test_push_pop();
        drain();
        clear_logs();
        for (int k = 0; k < 15; k++) begin
            req_pkt[0] = mk(m_op_mul, 32'(k), 32'(k + 1));
            req_valid  = (k < 4) ? 4'b0001 : 4'b0000;
            cdb_ready  = (k == 8);
            if (k == 8 || k == 9) begin
                n_cmp++;
                if (int'(u_dut.fifo_count) != 3) begin
                    n_err++;
                    $display("FAIL pushpop_occupancy k=%0d got=%0d exp=3", k, u_dut.fifo_count);
                end
            end
            tick();
        end
        drain();
        compare_order("pushpop");
    endtask

    task automatic test_random();
        clear_logs();
        for (int k = 0; k < 400; k++) begin
            req_valid = NR'($urandom);
            rand_pkts();
            cdb_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; n_grants = 0; tagc = 0; cyc = 0; mptr = 0;
        rst = 1'b1; flush = 1'b0; cdb_ready = 1'b1; req_valid = '0; req_pkt = '0;
        flush_b = 1'b0; cr_b = 1'b1; rv_b = '0; rp_b = '0;
        foreach (pipe_a[k]) begin pipe_a[k] = '0; pipe_b[k] = '0; end
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_flush();
        test_mulhu();
        test_push_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
